// File: rtl/enc_pkg.sv
// Shared types and sizes for the sequential 8-to-3 encoder.
// Holds the FSM state encoding and a popcount helper for the pending count.
package enc_pkg;

    localparam int N_LINES = 8;
    localparam int CODE_W  = 3;
    localparam int CNT_W   = 4;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_e;

    function automatic logic [CNT_W-1:0] popcount8(input logic [N_LINES-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < N_LINES; i++) begin
            c = c + CNT_W'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/encoder_8to3_seq_if.sv
// Request/code handshake bundle between a request source and the encoder.
// The slave modport is the encoder side; master is the source/consumer side.
interface encoder_8to3_seq_if;

    logic [enc_pkg::N_LINES-1:0] req_in;
    logic                        req_load;
    logic                        busy;
    logic [enc_pkg::CODE_W-1:0]  code_out;
    logic                        code_valid;
    logic                        code_ready;
    logic [enc_pkg::CNT_W-1:0]   pend_cnt;
    logic                        empty_pulse;
    logic                        done_pulse;

    modport slave (
        input  req_in, req_load, code_ready,
        output busy, code_out, code_valid, pend_cnt, empty_pulse, done_pulse
    );

    modport master (
        output req_in, req_load, code_ready,
        input  busy, code_out, code_valid, pend_cnt, empty_pulse, done_pulse
    );

endinterface

// File: rtl/encoder_8to3_seq_prio_enc8.sv
// Combinational 8-line priority encoder; HIGH_FIRST picks bit 7 (1) or bit 0 (0) as winner.
// Zero latency; any_o is low and idx_o is 0 when no line is set.
module prio_enc8
    import enc_pkg::*;
#(
    parameter bit HIGH_FIRST = 1'b0
) (
    input  logic [N_LINES-1:0] vec_i,
    output logic [CODE_W-1:0]  idx_o,
    output logic               any_o
);

    logic [CODE_W-1:0] idx_d;
    logic              found_d;
    logic [CODE_W-1:0] k;

    always_comb begin
        idx_d   = '0;
        found_d = 1'b0;
        k       = '0;
        for (int i = 0; i < N_LINES; i++) begin
            k = HIGH_FIRST ? CODE_W'(N_LINES - 1 - i) : CODE_W'(i);
            if (vec_i[k] && !found_d) begin
                idx_d   = k;
                found_d = 1'b1;
            end
        end
    end

    assign idx_o = idx_d;
    assign any_o = found_d;

endmodule

// File: rtl/encoder_8to3_seq.sv
// Snapshots 8 request lines and streams the index of each set line, one per valid/ready handshake.
// First code valid one cycle after load; code held while code_ready is low; loads ignored while busy.
module encoder_8to3_seq
    import enc_pkg::*;
#(
    parameter bit HIGH_FIRST = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    encoder_8to3_seq_if.slave  bus
);

    state_e               state_q, state_d;
    logic [N_LINES-1:0]   pending_q, pending_d;
    logic [CODE_W-1:0]    code_q, code_d;
    logic                 valid_q, valid_d;
    logic                 busy_q, busy_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 empty_q, empty_d;
    logic                 done_q, done_d;

    logic [CODE_W-1:0]    load_idx;
    logic                 load_any;
    logic [N_LINES-1:0]   pend_after;
    logic [CODE_W-1:0]    next_idx;
    logic                 next_any;

    // Snapshot with the currently presented code already retired.
    assign pend_after = pending_q & ~(N_LINES'(1) << code_q);

    prio_enc8 #(.HIGH_FIRST(HIGH_FIRST)) u_load_enc (
        .vec_i (bus.req_in),
        .idx_o (load_idx),
        .any_o (load_any)
    );

    prio_enc8 #(.HIGH_FIRST(HIGH_FIRST)) u_next_enc (
        .vec_i (pend_after),
        .idx_o (next_idx),
        .any_o (next_any)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pending_q <= '0;
            code_q    <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            cnt_q     <= '0;
            empty_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            code_q    <= code_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            cnt_q     <= cnt_d;
            empty_q   <= empty_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        code_d    = code_q;
        valid_d   = valid_q;
        busy_d    = busy_q;
        cnt_d     = cnt_q;
        empty_d   = 1'b0;
        done_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.req_load) begin
                    if (load_any) begin
                        pending_d = bus.req_in;
                        cnt_d     = popcount8(bus.req_in);
                        code_d    = load_idx;
                        valid_d   = 1'b1;
                        busy_d    = 1'b1;
                        state_d   = SCAN;
                    end else begin
                        empty_d   = 1'b1;
                    end
                end
            end
            SCAN: begin
                if (valid_q && bus.code_ready) begin
                    pending_d = pend_after;
                    if (next_any) begin
                        code_d = next_idx;
                        cnt_d  = cnt_q - CNT_W'(1);
                    end else begin
                        code_d  = '0;
                        cnt_d   = '0;
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.busy        = busy_q;
    assign bus.code_out    = code_q;
    assign bus.code_valid  = valid_q;
    assign bus.pend_cnt    = cnt_q;
    assign bus.empty_pulse = empty_q;
    assign bus.done_pulse  = done_q;

endmodule

// File: tb/tb_encoder_8to3_seq.sv
// Directed bench: one ascending and one descending encoder share the same stimulus.
module tb_encoder_8to3_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] req_in = 8'h00;
    logic       req_load = 1'b0;
    logic       code_ready = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    encoder_8to3_seq_if e0 ();
    encoder_8to3_seq_if e1 ();

    assign e0.req_in     = req_in;
    assign e0.req_load   = req_load;
    assign e0.code_ready = code_ready;
    assign e1.req_in     = req_in;
    assign e1.req_load   = req_load;
    assign e1.code_ready = code_ready;

    encoder_8to3_seq #(.HIGH_FIRST(1'b0)) dut_asc (.clk(clk), .rst_n(rst_n), .bus(e0));
    encoder_8to3_seq #(.HIGH_FIRST(1'b1)) dut_desc (.clk(clk), .rst_n(rst_n), .bus(e1));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [10:0] v0;
        logic [10:0] v1;
        rst_n = 1'b0; req_load = 1'b0; code_ready = 1'b0; req_in = 8'h00;
        step(); step();
        v0 = {e0.busy, e0.code_out, e0.code_valid, e0.pend_cnt, e0.empty_pulse, e0.done_pulse};
        v1 = {e1.busy, e1.code_out, e1.code_valid, e1.pend_cnt, e1.empty_pulse, e1.done_pulse};
        n_cmp++;
        if (v0 !== 11'd0) begin n_err++; $display("FAIL reset_asc: got %b want 0", v0); end
        n_cmp++;
        if (v1 !== 11'd0) begin n_err++; $display("FAIL reset_desc: got %b want 0", v1); end
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            step();
            v0 = {e0.busy, e0.code_out, e0.code_valid, e0.pend_cnt, e0.empty_pulse, e0.done_pulse};
            n_cmp++;
            if (v0 !== 11'd0) begin n_err++; $display("FAIL idle_hold cyc%0d: got %b want 0", c, v0); end
        end
    endtask

    task automatic test_ascending();
        logic [2:0] ea [4];
        logic [2:0] ed [4];
        ea = '{3'd0, 3'd2, 3'd5, 3'd7};
        ed = '{3'd7, 3'd5, 3'd2, 3'd0};
        code_ready = 1'b1; req_in = 8'b1010_0101; req_load = 1'b1;
        step();
        req_load = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (e0.code_valid !== 1'b1 || e0.code_out !== ea[i] || e0.pend_cnt !== 4'(4 - i) || e0.done_pulse !== 1'b0) begin
                n_err++;
                $display("FAIL asc_code%0d: got v=%b code=%0d cnt=%0d done=%b want v=1 code=%0d cnt=%0d done=0",
                         i, e0.code_valid, e0.code_out, e0.pend_cnt, e0.done_pulse, ea[i], 4 - i);
            end
            n_cmp++;
            if (e1.code_valid !== 1'b1 || e1.code_out !== ed[i]) begin
                n_err++;
                $display("FAIL desc_a5_code%0d: got v=%b code=%0d want v=1 code=%0d", i, e1.code_valid, e1.code_out, ed[i]);
            end
            step();
        end
        n_cmp++;
        if (e0.done_pulse !== 1'b1 || e0.code_valid !== 1'b0 || e0.busy !== 1'b0 || e0.pend_cnt !== 4'd0) begin
            n_err++;
            $display("FAIL asc_done: got done=%b v=%b busy=%b cnt=%0d want done=1 v=0 busy=0 cnt=0",
                     e0.done_pulse, e0.code_valid, e0.busy, e0.pend_cnt);
        end
        step();
        n_cmp++;
        if (e0.done_pulse !== 1'b0) begin n_err++; $display("FAIL asc_done_width: got %b want 0", e0.done_pulse); end
    endtask

    task automatic test_descending();
        int dones = 0;
        code_ready = 1'b0; req_in = 8'hFF; req_load = 1'b1;
        step();
        req_load = 1'b0; req_in = 8'h00;
        for (int k = 0; k < 8; k++) begin
            code_ready = 1'b0;
            n_cmp++;
            if (e1.code_valid !== 1'b1 || e1.code_out !== 3'(7 - k)) begin
                n_err++;
                $display("FAIL desc_code%0d: got v=%b code=%0d want v=1 code=%0d", k, e1.code_valid, e1.code_out, 7 - k);
            end
            step();
            n_cmp++;
            if (e1.code_valid !== 1'b1 || e1.code_out !== 3'(7 - k) || e1.pend_cnt !== 4'(8 - k)) begin
                n_err++;
                $display("FAIL desc_hold%0d: got v=%b code=%0d cnt=%0d want v=1 code=%0d cnt=%0d",
                         k, e1.code_valid, e1.code_out, e1.pend_cnt, 7 - k, 8 - k);
            end
            if (e1.done_pulse === 1'b1) dones++;
            code_ready = 1'b1;
            step();
            if (e1.done_pulse === 1'b1) dones++;
        end
        code_ready = 1'b0;
        n_cmp++;
        if (e1.done_pulse !== 1'b1 || e1.busy !== 1'b0 || e1.code_valid !== 1'b0) begin
            n_err++;
            $display("FAIL desc_done: got done=%b busy=%b v=%b want done=1 busy=0 v=0", e1.done_pulse, e1.busy, e1.code_valid);
        end
        step();
        if (e1.done_pulse === 1'b1) dones++;
        n_cmp++;
        if (dones != 1) begin n_err++; $display("FAIL desc_done_count: got %0d want 1", dones); end
    endtask

    task automatic test_empty();
        req_in = 8'h00; req_load = 1'b1;
        step();
        req_load = 1'b0;
        n_cmp++;
        if (e0.empty_pulse !== 1'b1 || e0.code_valid !== 1'b0 || e0.busy !== 1'b0 || e0.pend_cnt !== 4'd0) begin
            n_err++;
            $display("FAIL empty_load: got empty=%b v=%b busy=%b cnt=%0d want empty=1 v=0 busy=0 cnt=0",
                     e0.empty_pulse, e0.code_valid, e0.busy, e0.pend_cnt);
        end
        step();
        n_cmp++;
        if (e0.empty_pulse !== 1'b0 || e0.busy !== 1'b0) begin
            n_err++;
            $display("FAIL empty_width: got empty=%b busy=%b want 0 0", e0.empty_pulse, e0.busy);
        end
    endtask

    task automatic test_load_while_busy();
        code_ready = 1'b0; req_in = 8'h06; req_load = 1'b1;
        step();
        req_in = 8'hF0;
        step();
        req_load = 1'b0;
        n_cmp++;
        if (e0.code_out !== 3'd1 || e0.pend_cnt !== 4'd2 || e0.empty_pulse !== 1'b0) begin
            n_err++;
            $display("FAIL busy_load_ignored: got code=%0d cnt=%0d empty=%b want code=1 cnt=2 empty=0",
                     e0.code_out, e0.pend_cnt, e0.empty_pulse);
        end
        code_ready = 1'b1;
        step();
        n_cmp++;
        if (e0.code_out !== 3'd2 || e0.pend_cnt !== 4'd1 || e0.code_valid !== 1'b1) begin
            n_err++;
            $display("FAIL busy_second_code: got code=%0d cnt=%0d v=%b want code=2 cnt=1 v=1", e0.code_out, e0.pend_cnt, e0.code_valid);
        end
        req_in = 8'hF0; req_load = 1'b1;
        step();
        n_cmp++;
        if (e0.done_pulse !== 1'b1 || e0.code_valid !== 1'b0 || e0.busy !== 1'b0) begin
            n_err++;
            $display("FAIL reload_on_done: got done=%b v=%b busy=%b want done=1 v=0 busy=0", e0.done_pulse, e0.code_valid, e0.busy);
        end
        req_in = 8'h80;
        step();
        req_load = 1'b0; req_in = 8'h00;
        n_cmp++;
        if (e0.code_valid !== 1'b1 || e0.code_out !== 3'd7 || e0.pend_cnt !== 4'd1) begin
            n_err++;
            $display("FAIL reload_next: got v=%b code=%0d cnt=%0d want v=1 code=7 cnt=1", e0.code_valid, e0.code_out, e0.pend_cnt);
        end
        step();
        n_cmp++;
        if (e0.done_pulse !== 1'b1 || e0.code_valid !== 1'b0) begin
            n_err++;
            $display("FAIL single_bit_done: got done=%b v=%b want done=1 v=0", e0.done_pulse, e0.code_valid);
        end
        code_ready = 1'b0;
        step();
    endtask

    task automatic test_mid_reset();
        logic [10:0] v0;
        code_ready = 1'b0; req_in = 8'h0F; req_load = 1'b1;
        step();
        req_load = 1'b0; code_ready = 1'b1;
        step();
        code_ready = 1'b0;
        n_cmp++;
        if (e0.code_out !== 3'd1 || e0.pend_cnt !== 4'd3) begin
            n_err++;
            $display("FAIL midrst_pre: got code=%0d cnt=%0d want code=1 cnt=3", e0.code_out, e0.pend_cnt);
        end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        v0 = {e0.busy, e0.code_out, e0.code_valid, e0.pend_cnt, e0.empty_pulse, e0.done_pulse};
        n_cmp++;
        if (v0 !== 11'd0) begin n_err++; $display("FAIL midrst_clear: got %b want 0", v0); end
        step();
        n_cmp++;
        if (e0.done_pulse !== 1'b0 || e0.code_valid !== 1'b0) begin
            n_err++;
            $display("FAIL midrst_no_done: got done=%b v=%b want 0 0", e0.done_pulse, e0.code_valid);
        end
        req_in = 8'h10; req_load = 1'b1;
        step();
        req_load = 1'b0;
        n_cmp++;
        if (e0.code_valid !== 1'b1 || e0.code_out !== 3'd4 || e0.pend_cnt !== 4'd1) begin
            n_err++;
            $display("FAIL midrst_reload: got v=%b code=%0d cnt=%0d want v=1 code=4 cnt=1", e0.code_valid, e0.code_out, e0.pend_cnt);
        end
        code_ready = 1'b1;
        step();
        n_cmp++;
        if (e0.done_pulse !== 1'b1) begin n_err++; $display("FAIL midrst_done: got %b want 1", e0.done_pulse); end
        code_ready = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_ascending();
        test_descending();
        test_empty();
        test_load_while_busy();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
